// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: latches instructions and sequences FETCH/DECODE/execute states.
// Latency: R/I/branch/jal retire 3 cycles after FETCH entry; sw 3+W; lw 4+W (W = wait cycles).
// Backpressure: MEM_RD/MEM_WR hold with stable controls while mem_ready is low.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   rom_data         - instruction word for the current PC (latched in FETCH)
//   zero             - ALU zero flag, used in BRANCH
//   mem_ready        - data memory completes the current request this cycle
//   instr_q          - latched instruction register
//   immsrc, alu_src, alu_ctrl, result_src - datapath selects
//   reg_write, mem_req, mem_we, pc_write, pc_src - datapath strobes
//   retire           - one-cycle pulse per completed instruction
//   illegal          - sticky unsupported-encoding flag, cleared only by rst
module multicycle_control #(
  parameter logic [31:0] RESET_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rom_data,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [31:0] instr_q,
  output logic [1:0]  immsrc,
  output logic        alu_src,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  result_src,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_write,
  output logic        pc_src,
  output logic        retire,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t state, next_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      instr_q <= RESET_INSTR;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) begin
        instr_q <= rom_data;
      end
      // Set on the DECODE->TRAP edge so the flag is already high in the first TRAP cycle.
      if (next_state == S_TRAP) begin
        illegal <= 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    immsrc     = 2'b00;
    alu_src    = 1'b0;
    alu_ctrl   = 3'b000;
    result_src = 2'b00;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    retire     = 1'b0;

    case (state)
      S_FETCH: begin
        next_state = S_DECODE;
      end

      S_DECODE: begin
        case (opcode)
          OP_R:
            if (funct3 == 3'b000 && (funct7 == 7'b0000000 || funct7 == 7'b0100000))
              next_state = S_EXEC_R;
            else
              next_state = S_TRAP;
          OP_I:
            next_state = (funct3 == 3'b000) ? S_EXEC_I : S_TRAP;
          OP_LOAD:
            next_state = (funct3 == 3'b010) ? S_MEM_RD : S_TRAP;
          OP_STORE:
            next_state = (funct3 == 3'b010) ? S_MEM_WR : S_TRAP;
          OP_BRANCH:
            next_state = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
          OP_JAL:
            next_state = S_JAL;
          default:
            next_state = S_TRAP;
        endcase
      end

      S_EXEC_R: begin
        alu_ctrl   = funct7[5] ? 3'b001 : 3'b000;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_RD: begin
        alu_src = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          next_state = S_WB_MEM;
        end
      end

      S_WB_MEM: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_MEM_WR: begin
        immsrc  = 2'b01;
        alu_src = 1'b1;
        mem_req = 1'b1;
        mem_we  = 1'b1;
        // A store completes in the ready cycle itself; no writeback state follows.
        if (mem_ready) begin
          pc_write   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end

      S_BRANCH: begin
        immsrc     = 2'b10;
        alu_ctrl   = 3'b001;
        pc_write   = 1'b1;
        pc_src     = funct3[0] ? ~zero : zero;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_JAL: begin
        immsrc     = 2'b11;
        result_src = 2'b10;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_TRAP: begin
        next_state = S_TRAP;
      end

      default: begin
        next_state = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction expected-output model.
// Latency: one instruction walked cycle by cycle from FETCH to its retire (or trap/abort).
// Backpressure: random mem_ready wait counts for lw/sw, plus resets during lw waits.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rom_data;
  logic        zero;
  logic        mem_ready;
  logic [31:0] instr_q;
  logic [1:0]  immsrc;
  logic        alu_src;
  logic [2:0]  alu_ctrl;
  logic [1:0]  result_src;
  logic        reg_write;
  logic        mem_req;
  logic        mem_we;
  logic        pc_write;
  logic        pc_src;
  logic        retire;
  logic        illegal;

  multicycle_control dut (
    .clk(clk), .rst(rst), .rom_data(rom_data), .zero(zero), .mem_ready(mem_ready),
    .instr_q(instr_q), .immsrc(immsrc), .alu_src(alu_src), .alu_ctrl(alu_ctrl),
    .result_src(result_src), .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we),
    .pc_write(pc_write), .pc_src(pc_src), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;
  int obs_ret  = 0;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_JAL = 5, K_ILL = 6;
  localparam logic [31:0] NOP = 32'h00000013;

  logic [13:0] obs;
  assign obs = {immsrc, alu_src, alu_ctrl, result_src,
                reg_write, mem_req, mem_we, pc_write, pc_src, retire};

  always @(negedge clk) if (retire === 1'b1) obs_ret++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] vec(input logic [1:0] imm, input logic asrc,
                                      input logic [2:0] actl, input logic [1:0] res,
                                      input logic rw, input logic mr, input logic mw,
                                      input logic pw, input logic ps, input logic rt);
    return {imm, asrc, actl, res, rw, mr, mw, pw, ps, rt};
  endfunction

  function automatic int classify(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    case (w[6:0])
      7'b0110011: return (f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ? K_R : K_ILL;
      7'b0010011: return (f3 == 3'd0) ? K_I : K_ILL;
      7'b0000011: return (f3 == 3'd2) ? K_LW : K_ILL;
      7'b0100011: return (f3 == 3'd2) ? K_SW : K_ILL;
      7'b1100011: return (f3 <= 3'd1) ? K_BR : K_ILL;
      7'b1101111: return K_JAL;
      default:    return K_ILL;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the full control vector and the illegal flag for the current cycle.
  task automatic check_cycle(input string tag, input logic [13:0] e, input logic ill);
    #1;
    chk(tag, {18'd0, obs}, {18'd0, e});
    chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, ill});
  endtask

  task automatic check_after_reset(input string tag);
    #1;
    chk({tag, "_instr"}, instr_q, NOP);
    chk({tag, "_vec"}, {18'd0, obs}, 32'd0);
    chk({tag, "_ill"}, {31'd0, illegal}, 32'd0);
  endtask

  // Runs one instruction starting in a FETCH cycle and leaves the bench in the next FETCH cycle.
  // abort_at >= 0 asserts rst in that lw wait cycle instead of completing the load.
  task automatic run_instr(input logic [31:0] w, input int waits, input logic zv,
                           input int abort_at);
    int kind;
    logic taken;
    kind = classify(w);

    rom_data  = w;
    zero      = 1'($urandom);
    mem_ready = 1'($urandom);
    check_cycle("fetch", 14'd0, 1'b0);
    step();

    rom_data  = $urandom;
    mem_ready = 1'($urandom);
    #1;
    chk("decode_instr", instr_q, w);
    check_cycle("decode", 14'd0, 1'b0);
    step();

    case (kind)
      K_R: begin
        mem_ready = 1'($urandom);
        check_cycle("exec_r", vec(2'b00, 1'b0, w[30] ? 3'b001 : 3'b000, 2'b00,
                                  1, 0, 0, 1, 0, 1), 1'b0);
        exp_ret++;
      end
      K_I: begin
        mem_ready = 1'($urandom);
        check_cycle("exec_i", vec(2'b00, 1'b1, 3'b000, 2'b00, 1, 0, 0, 1, 0, 1), 1'b0);
        exp_ret++;
      end
      K_LW: begin
        for (int i = 0; i <= waits; i++) begin
          mem_ready = (i == waits);
          if (i == abort_at) begin
            rst = 1'b1;
            check_cycle("lw_abort_req", vec(2'b00, 1'b1, 3'b000, 2'b00, 0, 1, 0, 0, 0, 0), 1'b0);
            step();
            rst = 1'b0;
            check_after_reset("lw_abort");
            return;
          end
          check_cycle("lw_req", vec(2'b00, 1'b1, 3'b000, 2'b00, 0, 1, 0, 0, 0, 0), 1'b0);
          if (i < waits) step();
        end
        step();
        mem_ready = 1'($urandom);
        check_cycle("lw_wb", vec(2'b00, 1'b0, 3'b000, 2'b01, 1, 0, 0, 1, 0, 1), 1'b0);
        exp_ret++;
      end
      K_SW: begin
        for (int i = 0; i <= waits; i++) begin
          mem_ready = (i == waits);
          if (i == waits)
            check_cycle("sw_done", vec(2'b01, 1'b1, 3'b000, 2'b00, 0, 1, 1, 1, 0, 1), 1'b0);
          else
            check_cycle("sw_wait", vec(2'b01, 1'b1, 3'b000, 2'b00, 0, 1, 1, 0, 0, 0), 1'b0);
          if (i < waits) step();
        end
        exp_ret++;
      end
      K_BR: begin
        zero      = zv;
        mem_ready = 1'($urandom);
        taken     = (w[14:12] == 3'd0) ? zv : !zv;
        check_cycle("branch", vec(2'b10, 1'b0, 3'b001, 2'b00, 0, 0, 0, 1, taken, 1), 1'b0);
        exp_ret++;
      end
      K_JAL: begin
        mem_ready = 1'($urandom);
        check_cycle("jal", vec(2'b11, 1'b0, 3'b000, 2'b10, 1, 0, 0, 1, 1, 1), 1'b0);
        exp_ret++;
      end
      default: begin
        for (int i = 0; i < 12; i++) begin
          mem_ready = 1'($urandom);
          zero      = 1'($urandom);
          check_cycle("trap", 14'd0, 1'b1);
          step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_after_reset("trap_reset");
        return;
      end
    endcase
    step();
    mem_ready = 1'b0;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  ops [6];
    int sel;
    ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
    ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
    w   = $urandom;
    sel = $urandom_range(0, 6);
    if (sel < 6) w[6:0] = ops[sel];
    case ($urandom_range(0, 4))
      0: w[14:12] = 3'd0;
      1: w[14:12] = 3'd1;
      2: w[14:12] = 3'd2;
      3: w[14:12] = (sel == 2 || sel == 3) ? 3'd2 : 3'd0;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    int waits;
    int abort_at;
    rst = 1'b1; rom_data = 32'd0; zero = 1'b0; mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check_after_reset("reset");

    run_instr(32'h00500093, 0, 1'b0, -1);
    run_instr(32'h0040A103, 2, 1'b0, -1);
    run_instr(32'h0020A423, 0, 1'b0, -1);
    run_instr(32'hFE000CE3, 0, 1'b1, -1);
    run_instr(32'h00009463, 0, 1'b1, -1);
    run_instr(32'h010000EF, 0, 1'b0, -1);
    run_instr(32'h40208033, 0, 1'b0, -1);
    run_instr(32'hFFFFFFFF, 0, 1'b0, -1);
    run_instr(32'h0040A103, 3, 1'b0, 1);
    run_instr(32'h0020A423, 3, 1'b0, -1);

    for (int n = 0; n < 150; n++) begin
      w     = gen_instr();
      waits = $urandom_range(0, 3);
      abort_at = -1;
      if (waits > 0 && $urandom_range(0, 3) == 0) abort_at = $urandom_range(0, waits - 1);
      run_instr(w, waits, 1'($urandom), abort_at);
    end

    @(negedge clk);
    chk("retire_count", obs_ret, exp_ret);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
